// File: rtl/idu_pkg.sv
// Shared decode definitions for the decode stage.
// Contents: bus widths, RV32I opcode and funct3 encodings, ALU operation
// enum, immediate format enum, stage state enum and ctrl bit positions.
package idu_pkg;

   localparam int IF2ID_W = 64;
   localparam int ID2EX_W = 176;
   localparam int CTRL_W  = 16;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam int CTRL_SRC1_PC  = 4;
   localparam int CTRL_SRC2_IMM = 5;
   localparam int CTRL_RF_WEN   = 6;
   localparam int CTRL_MEM_REN  = 7;
   localparam int CTRL_MEM_WEN  = 8;
   localparam int CTRL_WB_PC4   = 9;
   localparam int CTRL_EBREAK   = 10;
   localparam int CTRL_ECALL    = 11;
   localparam int CTRL_ILLEGAL  = 12;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_COPY2 = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
   } imm_fmt_e;

   typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} idu_state_e;

   // alt selects SUB / SRA (funct7[5]) where it applies.
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/idu_stage_imm_gen.sv
// Immediate generator for RV32I.
// Ports: inst_i (instruction), imm_o (sign-extended immediate),
//        fmt_o (format chosen from the opcode; FMT_NONE for R-type/unknown).
module idu_stage_imm_gen
   import idu_pkg::*;
(
   input  logic [31:0] inst_i,
   output logic [31:0] imm_o,
   output imm_fmt_e    fmt_o
);

   always_comb begin
      fmt_o = FMT_NONE;
      case (inst_i[6:0])
         OPC_LUI, OPC_AUIPC:                         fmt_o = FMT_U;
         OPC_JAL:                                    fmt_o = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: fmt_o = FMT_I;
         OPC_BRANCH:                                 fmt_o = FMT_B;
         OPC_STORE:                                  fmt_o = FMT_S;
         default:                                    fmt_o = FMT_NONE;
      endcase
   end

   always_comb begin
      imm_o = '0;
      case (fmt_o)
         FMT_I: imm_o = {{21{inst_i[31]}}, inst_i[30:20]};
         FMT_S: imm_o = {{21{inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
         FMT_B: imm_o = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         FMT_U: imm_o = {inst_i[31:12], 12'h000};
         FMT_J: imm_o = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/idu_stage.sv
// RV32I decode stage: holds one {pc, inst} from fetch, returns dnpc to fetch
// and forwards the decoded bundle to execute. The two downstream handshakes
// are independent; the entry retires when both have completed.
// Ports: clk/rst (async, active-low); if_to_id_* fetch bundle in;
//        id_to_if_* dnpc out; rf_raddr*/rf_rdata* register-file read;
//        id_to_ex_* decoded bundle {pc, inst, imm, src1, src2, ctrl} out.
//
// state    | meaning
// ST_EMPTY | no entry held, ready for fetch
// ST_HOLD  | entry held; pc_sent_q/ex_sent_q mark completed handshakes
module idu_stage
   import idu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [IF2ID_W-1:0]     if_to_id_bus,
   input  logic                   if_to_id_valid,
   output logic                   id_to_if_ready,
   output logic [ADDR_WIDTH-1:0]  id_to_if_bus,
   output logic                   id_to_if_valid,
   input  logic                   if_to_id_ready,
   output logic [4:0]             rf_raddr1,
   output logic [4:0]             rf_raddr2,
   input  logic [DATA_WIDTH-1:0]  rf_rdata1,
   input  logic [DATA_WIDTH-1:0]  rf_rdata2,
   output logic [ID2EX_W-1:0]     id_to_ex_bus,
   output logic                   id_to_ex_valid,
   input  logic                   ex_to_id_ready
);

   idu_state_e            state_q, state_d;
   logic                  pc_sent_q, pc_sent_d;
   logic                  ex_sent_q, ex_sent_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]           inst_q, inst_d;

   logic id_valid, if_hs, ex_hs, retire, capture;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_EMPTY;
         pc_sent_q <= 1'b0;
         ex_sent_q <= 1'b0;
         pc_q      <= '0;
         inst_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_sent_q <= pc_sent_d;
         ex_sent_q <= ex_sent_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
      end
   end

   assign id_valid       = (state_q == ST_HOLD);
   assign id_to_if_valid = id_valid && !pc_sent_q;
   assign id_to_ex_valid = id_valid && !ex_sent_q;
   assign if_hs          = id_to_if_valid && if_to_id_ready;
   assign ex_hs          = id_to_ex_valid && ex_to_id_ready;
   assign retire         = id_valid && (pc_sent_q || if_hs) && (ex_sent_q || ex_hs);
   assign id_to_if_ready = !id_valid || retire;
   assign capture        = if_to_id_valid && id_to_if_ready;

   always_comb begin
      state_d   = state_q;
      pc_sent_d = pc_sent_q;
      ex_sent_d = ex_sent_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      if (capture) begin
         state_d   = ST_HOLD;
         pc_sent_d = 1'b0;
         ex_sent_d = 1'b0;
         pc_d      = if_to_id_bus[63:32];
         inst_d    = if_to_id_bus[31:0];
      end else if (retire) begin
         state_d   = ST_EMPTY;
         pc_sent_d = 1'b0;
         ex_sent_d = 1'b0;
      end else begin
         pc_sent_d = pc_sent_q || if_hs;
         ex_sent_d = ex_sent_q || ex_hs;
      end
   end

   // ---------------- decode ----------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm;
   imm_fmt_e    fmt;

   assign opcode    = inst_q[6:0];
   assign rd        = inst_q[11:7];
   assign funct3    = inst_q[14:12];
   assign funct7    = inst_q[31:25];
   assign rf_raddr1 = inst_q[19:15];
   assign rf_raddr2 = inst_q[24:20];

   idu_stage_imm_gen u_imm_gen (
      .inst_i (inst_q),
      .imm_o  (imm),
      .fmt_o  (fmt)
   );

   alu_op_e     alu_op;
   logic        src1_pc, src2_imm, rf_wen, mem_ren, mem_wen, wb_pc4;
   logic        ebreak, ecall, illegal;
   logic [CTRL_W-1:0] ctrl;

   always_comb begin
      alu_op   = ALU_ADD;
      src1_pc  = 1'b0;
      src2_imm = 1'b0;
      rf_wen   = 1'b0;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      wb_pc4   = 1'b0;
      ebreak   = 1'b0;
      ecall    = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OPC_LUI:   begin alu_op = ALU_COPY2; src2_imm = 1'b1; rf_wen = 1'b1; end
         OPC_AUIPC: begin src1_pc = 1'b1; src2_imm = 1'b1; rf_wen = 1'b1; end
         OPC_JAL:   begin src1_pc = 1'b1; src2_imm = 1'b1; rf_wen = 1'b1; wb_pc4 = 1'b1; end
         OPC_JALR: begin
            src2_imm = 1'b1; rf_wen = 1'b1; wb_pc4 = 1'b1;
            illegal  = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            alu_op  = ALU_SUB;
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LOAD: begin
            src2_imm = 1'b1; mem_ren = 1'b1; rf_wen = 1'b1;
            illegal  = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
         end
         OPC_STORE: begin
            src2_imm = 1'b1; mem_wen = 1'b1;
            illegal  = (funct3[2] || funct3 == 3'b011);
         end
         OPC_OP_IMM: begin
            alu_op   = alu_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
            src2_imm = 1'b1; rf_wen = 1'b1;
            if (funct3 == F3_SLL)
               illegal = (funct7 != 7'b0000000);
            else if (funct3 == F3_SR)
               illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         OPC_OP: begin
            alu_op  = alu_from_f3(funct3, funct7[5]);
            rf_wen  = 1'b1;
            // funct7=0100000 only exists for SUB and SRA
            illegal = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && (funct3 == F3_ADD || funct3 == F3_SR)));
         end
         OPC_SYSTEM: begin
            ebreak  = (inst_q == INST_EBREAK);
            ecall   = (inst_q == INST_ECALL);
            illegal = !(ebreak || ecall);
         end
         default: illegal = 1'b1;
      endcase
   end

   // An illegal instruction carries only its illegal flag downstream.
   always_comb begin
      ctrl = '0;
      if (illegal) begin
         ctrl[CTRL_ILLEGAL] = 1'b1;
      end else begin
         ctrl[3:0]           = alu_op;
         ctrl[CTRL_SRC1_PC]  = src1_pc;
         ctrl[CTRL_SRC2_IMM] = src2_imm;
         ctrl[CTRL_RF_WEN]   = rf_wen && (rd != 5'd0);
         ctrl[CTRL_MEM_REN]  = mem_ren;
         ctrl[CTRL_MEM_WEN]  = mem_wen;
         ctrl[CTRL_WB_PC4]   = wb_pc4;
         ctrl[CTRL_EBREAK]   = ebreak;
         ctrl[CTRL_ECALL]    = ecall;
      end
   end

   // ---------------- control flow ----------------
   logic                  br_eq, br_lt, br_ltu, br_taken;
   logic [ADDR_WIDTH-1:0] tgt, pc_plus4;

   assign br_eq    = (rf_rdata1 == rf_rdata2);
   assign br_lt    = ($signed(rf_rdata1) < $signed(rf_rdata2));
   assign br_ltu   = (rf_rdata1 < rf_rdata2);
   assign pc_plus4 = pc_q + ADDR_WIDTH'(4);
   // Only JALR uses an I-format immediate among the redirecting opcodes.
   assign tgt      = ((fmt == FMT_I) ? rf_rdata1 : pc_q) + imm;

   always_comb begin
      case (funct3)
         F3_BEQ:  br_taken = br_eq;
         F3_BNE:  br_taken = !br_eq;
         F3_BLT:  br_taken = br_lt;
         F3_BGE:  br_taken = !br_lt;
         F3_BLTU: br_taken = br_ltu;
         F3_BGEU: br_taken = !br_ltu;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      id_to_if_bus = pc_plus4;
      if (!illegal) begin
         case (opcode)
            OPC_JAL:    id_to_if_bus = tgt;
            OPC_JALR:   id_to_if_bus = {tgt[ADDR_WIDTH-1:1], 1'b0};
            OPC_BRANCH: id_to_if_bus = br_taken ? tgt : pc_plus4;
            default:    id_to_if_bus = pc_plus4;
         endcase
      end
   end

   assign id_to_ex_bus = {pc_q, inst_q, imm, rf_rdata1, rf_rdata2, ctrl};

endmodule
